ps2_key_decoder: RTL and testbench

Upstream input stage of the whack-a-mole game. Receives raw PS/2 keyboard clock/data lines, deframes 11-bit PS/2 frames, interprets set-2 scan-code prefixes, and delivers one single-cycle pulse per new key press on `oKeyboard_data` / `oKeyboard_data_en`. These feed the game FSM's `iKeyboard_data` / `iKeyboard_data_en` inputs directly. Break codes, extended keys and typematic repeats are filtered here, so the FSM sees exactly one event per physical press.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_frame_rx.sv | 145 ++++++++++++++
 rtl/ps2_key_decoder.sv | 88 ++++++++
 tb/tb_ps2_key_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard input stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Set-2 scan-code prefixes
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Defaults: 4-sample glitch filter, 1 ms frame timeout at 50 MHz
    localparam int FILTER_DEF  = 4;
    localparam int TIMEOUT_DEF = 50000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 bit layer: synchronize + filter the lines, deframe 11-bit frames, abort stalled frames.
// Latency: pin to edge detect 2 + FILTER cycles; byte_vld/frame_err are combinational on the stop/timeout cycle.
// Backpressure: none; byte_vld and frame_err are single-cycle strobes the consumer must take.
//
// Ports:
//   clk, reset_m         system clock, async active-low reset
//   ps2_clk, ps2_dat     raw PS/2 lines (asynchronous to clk)
//   byte_dat[7:0]        last deframed byte, valid while byte_vld is high
//   byte_vld             good frame received (stop=1, odd parity)
//   frame_err            parity error, stop-bit error or timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER  = FILTER_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset_m,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_dat,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER + 1);

    // Index 0 = PS/2 clock, index 1 = PS/2 data
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] flt_cnt [2];
    logic          clk_prev;

    logic          fall;
    logic          dat;

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_bit_n;
    logic [15:0]   to_cnt;
    logic          timeout_hit;

    // Synchronizer and glitch filter; everything idles high like the bus.
    // A filtered level only changes after FILTER consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            sync1    <= {ps2_dat, ps2_clk};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FW'(FILTER - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev & ~filt[0];
    assign dat  = filt[1];

    // An edge in the same cycle as the limit wins, so the abort requires !fall.
    assign timeout_hit = (state != IDLE) && !fall && (to_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par_bit <= par_bit_n;
            if (fall || state_n == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_bit_n = par_bit;
        byte_vld  = 1'b0;
        frame_err = 1'b0;

        if (timeout_hit) begin
            state_n   = IDLE;
            frame_err = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    // A high data line here is not a start bit; ignore it silently
                    if (!dat) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {dat, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_bit_n = dat;
                    state_n   = STOP;
                end
                STOP: begin
                    if (dat && (^{shift, par_bit})) begin
                        byte_vld = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign byte_dat = shift;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: one strobe per new key press; break, extended and typematic codes dropped.
// Latency: oKeyboard_data_en one clk after the stop-bit edge is detected.
// Backpressure: none; the consumer must sample on the strobe.
//
// Ports:
//   clk, reset_m           50 MHz system clock, async active-low reset
//   ps2_clk, ps2_dat       raw PS/2 lines
//   oKeyboard_data[7:0]    make code of newest press, held between strobes
//   oKeyboard_data_en      single-cycle valid strobe
//   oFrame_err             single-cycle parity/stop/timeout error strobe
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER  = FILTER_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset_m,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] oKeyboard_data,
    output logic       oKeyboard_data_en,
    output logic       oFrame_err
);

    logic [7:0] rx_dat;
    logic       rx_vld;
    logic       rx_err;

    logic       brk;
    logic       ext;
    logic [7:0] last_make;

    ps2_frame_rx #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk       (clk),
        .reset_m   (reset_m),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .byte_dat  (rx_dat),
        .byte_vld  (rx_vld),
        .frame_err (rx_err)
    );

    // rx_vld and rx_err are mutually exclusive, so the strobes never overlap.
    always_ff @(posedge clk or negedge reset_m) begin
        if (!reset_m) begin
            brk               <= 1'b0;
            ext               <= 1'b0;
            last_make         <= '0;
            oKeyboard_data    <= '0;
            oKeyboard_data_en <= 1'b0;
            oFrame_err        <= 1'b0;
        end else begin
            oKeyboard_data_en <= 1'b0;
            oFrame_err        <= 1'b0;
            if (rx_err) begin
                // Prefix context is lost with the frame; last_make survives so a
                // held key does not re-trigger after a glitch.
                oFrame_err <= 1'b1;
                brk        <= 1'b0;
                ext        <= 1'b0;
            end else if (rx_vld) begin
                if (rx_dat == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_dat == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (brk) begin
                    // Release of the held key re-arms it for the next press
                    if (rx_dat == last_make) begin
                        last_make <= '0;
                    end
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else if (ext) begin
                    ext <= 1'b0;
                end else if (rx_dat != last_make) begin
                    last_make         <= rx_dat;
                    oKeyboard_data    <= rx_dat;
                    oKeyboard_data_en <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int FLT = 4;
    localparam int TO  = 500;

    logic       clk;
    logic       reset_m;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] oKeyboard_data;
    logic       oKeyboard_data_en;
    logic       oFrame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] dat;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_vld;
        logic [7:0] exp_dat;
        bit         exp_err;
    } vec_t;

    vec_t tbl [19];

    ps2_key_decoder #(
        .FILTER  (FLT),
        .TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .reset_m           (reset_m),
        .ps2_clk           (ps2_clk),
        .ps2_dat           (ps2_dat),
        .oKeyboard_data    (oKeyboard_data),
        .oKeyboard_data_en (oKeyboard_data_en),
        .oFrame_err        (oFrame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input int want);
        checks++;
        if (q.size() != want) begin
            errors++;
            $display("FAIL %s pending_events actual=%0d required=%0d", name, q.size(), want);
        end
    endtask

    // One PS/2 bit: data set while clock high, then a 10-cycle low phase.
    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_clks(5);
        ps2_clk = 1'b0;
        wait_clks(10);
        ps2_clk = 1'b1;
        wait_clks(5);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(~bad_stop);
        ps2_dat = 1'b1;
        wait_clks(20);
    endtask

    task automatic push_key(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.dat    = d;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.dat    = 8'h00;
        q.push_back(e);
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected event.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (oKeyboard_data_en && oFrame_err) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap actual=both_high required=exclusive");
            end
            if (oKeyboard_data_en) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL key_strobe actual=%0h required=no_strobe", oKeyboard_data);
                end else begin
                    e = q.pop_front();
                    if (e.is_err || oKeyboard_data !== e.dat) begin
                        errors++;
                        $display("FAIL key_strobe actual=key_%0h required=%s_%0h",
                                 oKeyboard_data, e.is_err ? "err" : "key", e.dat);
                    end
                end
            end
            if (oFrame_err) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_err actual=err required=no_strobe");
                end else begin
                    e = q.pop_front();
                    if (!e.is_err) begin
                        errors++;
                        $display("FAIL frame_err actual=err required=key_%0h", e.dat);
                    end
                end
            end
        end
    endtask

    initial begin
        // byte, bad_par, bad_stop, exp_vld, exp_dat, exp_err
        tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0}; // first press
        tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // break prefix
        tbl[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // release, clears last_make
        tbl[3]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0}; // press again
        tbl[4]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // typematic
        tbl[5]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // typematic
        tbl[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // extended make
        tbl[7]  = '{8'h75, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // extended break
        tbl[9]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{8'h75, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{8'h1D, 1'b0, 1'b0, 1'b1, 8'h1D, 1'b0}; // normal key after extended
        tbl[12] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}; // parity error
        tbl[13] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1}; // stop-bit error
        tbl[14] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0}; // errors kept last_make=1D
        tbl[15] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // break prefix...
        tbl[16] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}; // ...lost to a bad frame
        tbl[17] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // brk gone: typematic
        tbl[18] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // still held

        reset_m = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        fork
            monitor();
        join_none

        wait_clks(5);
        chk("reset_data", 32'(oKeyboard_data), 32'h0);
        chk("reset_en", 32'(oKeyboard_data_en), 32'h0);
        chk("reset_err", 32'(oFrame_err), 32'h0);
        reset_m = 1'b1;
        wait_clks(10);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].exp_vld) push_key(tbl[i].exp_dat);
            if (tbl[i].exp_err) push_err();
            send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
            chk_q($sformatf("vec%0d", i), 0);
        end
        chk("held_data", 32'(oKeyboard_data), 32'h1C);

        // Timeout: start bit + 4 data bits, then the bus goes quiet
        push_err();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_clks(TO - 30);
        chk_q("timeout_early", 1);
        wait_clks(40);
        chk_q("timeout_fired", 0);
        push_key(8'h23);
        send_frame(8'h23, 1'b0, 1'b0);
        chk_q("after_timeout", 0);

        // Reset mid-frame
        push_key(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk_q("pre_reset_key", 0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset_m = 1'b0;
        #1;
        chk("midreset_data", 32'(oKeyboard_data), 32'h0);
        chk("midreset_en", 32'(oKeyboard_data_en), 32'h0);
        chk("midreset_err", 32'(oFrame_err), 32'h0);
        wait_clks(10);
        reset_m = 1'b1;
        wait_clks(20);
        push_key(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk_q("post_reset_key", 0);
        chk("final_data", 32'(oKeyboard_data), 32'h1C);

        wait_clks(20);
        chk_q("drain", 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
